// File: rtl/cnn_rd_arb.sv
// cnn_rd_arb
//   Shares the single memory read port between the CNN's three read clients
//   (0 = picture window, 1 = weights, 2 = bias). Round-robin arbitration, one
//   outstanding read at a time. The memory response is routed back to the
//   owning client, and a watchdog ends a read that never gets a response.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cl_req            per-client level request, held until that client's cl_valid
//   cl_addr, cl_size  per-client start address / byte count, client i at slice i
//   cl_valid          one-cycle response strobe to the owning client
//   cl_data           response data (shared), qualified by cl_valid
//   cl_last_valid     index of the last valid byte, qualified by cl_valid
//   mem_req           read request to memory, held for the whole REQ phase
//   mem_start_addr    latched start address of the owner
//   mem_size_bytes    latched byte count of the owner
//   mem_valid         memory response strobe
//   mem_data          memory read data
//   mem_last_valid    memory last valid byte index
//   busy              high whenever the arbiter is not idle
//   owner             index of the current or last granted client
//   err_timeout       one-cycle pulse when a read times out
//   err_id            client that timed out; held until the next timeout

module cnn_rd_arb #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned ADDR_WIDTH  = 19,
    parameter int unsigned SIZE_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned LV_WIDTH    = 5,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [NUM_REQ-1:0]            cl_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] cl_addr,
    input  logic [NUM_REQ*SIZE_WIDTH-1:0] cl_size,
    output logic [NUM_REQ-1:0]            cl_valid,
    output logic [DATA_WIDTH-1:0]         cl_data,
    output logic [LV_WIDTH-1:0]           cl_last_valid,

    output logic                          mem_req,
    output logic [ADDR_WIDTH-1:0]         mem_start_addr,
    output logic [SIZE_WIDTH-1:0]         mem_size_bytes,
    input  logic                          mem_valid,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    input  logic [LV_WIDTH-1:0]           mem_last_valid,

    output logic                          busy,
    output logic [1:0]                    owner,
    output logic                          err_timeout,
    output logic [1:0]                    err_id
);

    localparam int unsigned ID_WIDTH  = 2;
    localparam int unsigned CNT_WIDTH = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    // Counter value on the last REQ cycle before the watchdog fires.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StReq,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [ID_WIDTH-1:0]   owner_q, owner_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   err_id_q, err_id_d;
    logic                  mem_req_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic [CNT_WIDTH-1:0]  tmo_cnt_q, tmo_cnt_d;

    logic                  arb_found;
    logic [ID_WIDTH-1:0]   arb_win;
    logic [ID_WIDTH-1:0]   arb_idx;
    logic                  in_req;
    logic                  tmo_fire;
    logic                  req_end;

    //------------------------------------------------------------------------
    // Round-robin search: start at rr_ptr and wrap, first active request wins.
    //------------------------------------------------------------------------
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            arb_idx = ID_WIDTH'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!arb_found && cl_req[arb_idx]) begin
                arb_found = 1'b1;
                arb_win   = arb_idx;
            end
        end
    end

    // A response in the terminal-count cycle takes precedence over the timeout.
    assign in_req   = (state_q == StReq);
    assign tmo_fire = in_req && !mem_valid && (tmo_cnt_q == CNT_LAST);
    assign req_end  = in_req && (mem_valid || tmo_fire);

    //------------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    //------------------------------------------------------------------------
    // FSM: next state
    //------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (arb_found) state_d = StGrant;
            StGrant: state_d = StReq;
            StReq:   if (req_end) state_d = StDone;
            // Requests are ignored here so the owner can drop cl_req in time.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    //------------------------------------------------------------------------
    // FSM: outputs
    //------------------------------------------------------------------------
    always_comb begin
        cl_valid      = '0;
        cl_data       = '0;
        cl_last_valid = '0;
        if (in_req) begin
            cl_data       = mem_data;
            cl_last_valid = mem_last_valid;
            if (mem_valid) begin
                cl_valid[owner_q] = 1'b1;
            end
        end
    end

    assign busy           = (state_q != StIdle);
    assign mem_req        = mem_req_q;
    assign mem_start_addr = addr_q;
    assign mem_size_bytes = size_q;
    assign owner          = owner_q;
    assign err_timeout    = tmo_fire;
    // Report the timed-out client in the same cycle as the pulse, then hold it.
    assign err_id         = err_id_d;

    //------------------------------------------------------------------------
    // Datapath next-state
    //------------------------------------------------------------------------
    always_comb begin
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        err_id_d  = err_id_q;
        addr_d    = addr_q;
        size_d    = size_q;
        tmo_cnt_d = '0;

        if (state_q == StIdle && arb_found) begin
            owner_d = arb_win;
            addr_d  = cl_addr[32'(arb_win) * ADDR_WIDTH +: ADDR_WIDTH];
            size_d  = cl_size[32'(arb_win) * SIZE_WIDTH +: SIZE_WIDTH];
        end

        if (in_req) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        if (req_end) begin
            rr_ptr_d = ID_WIDTH'((32'(owner_q) + 1) % NUM_REQ);
        end

        if (tmo_fire) begin
            err_id_d = owner_q;
        end
    end

    //------------------------------------------------------------------------
    // Datapath registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            err_id_q  <= '0;
            mem_req_q <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            tmo_cnt_q <= '0;
        end else begin
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            err_id_q  <= err_id_d;
            // Registered request: high exactly for the cycles spent in REQ.
            mem_req_q <= (state_d == StReq);
            addr_q    <= addr_d;
            size_q    <= size_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: doc/cnn_rd_arb.md
Name: cnn_rd_arb

Overview:
- Shares the single memory read port between the CNN's three read clients: picture window (pic), weights (wgt) and bias.
- Round-robin arbitration, one outstanding transaction at a time.
- Routes the memory response back to the owning client.
- Watchdog timeout flags a hung read.
- Sits between the cnn core's mem_intf_read_pic/wgt/bias channels and the memory interface read side.

Parameters:
NUM_REQ, 3, number of read clients; index 0=pic, 1=wgt, 2=bias
ADDR_WIDTH, 19, byte address width
SIZE_WIDTH, 8, request size field width (bytes)
DATA_WIDTH, 256, memory read data bus (32 bytes x 8 bit)
LV_WIDTH, 5, last_valid byte-index width, $clog2(DATA_WIDTH/8)
TIMEOUT_CYC, 1024, max cycles from mem_req assertion to mem_valid

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cl_req  in  NUM_REQ  per-client read request, level, held until the client's cl_valid
cl_addr  in  NUM_REQ*ADDR_WIDTH  per-client start address, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
cl_size  in  NUM_REQ*SIZE_WIDTH  per-client byte count, packed as above
cl_valid  out  NUM_REQ  one-cycle response strobe to the owning client
cl_data  out  DATA_WIDTH  response data, shared by all clients, qualified by cl_valid
cl_last_valid  out  LV_WIDTH  index of the last valid byte, qualified by cl_valid
mem_req  out  1  read request to memory
mem_start_addr  out  ADDR_WIDTH  latched start address of the owner
mem_size_bytes  out  SIZE_WIDTH  latched size of the owner
mem_valid  in  1  memory response strobe
mem_data  in  DATA_WIDTH  memory read data
mem_last_valid  in  LV_WIDTH  memory last valid byte index
busy  out  1  high whenever state != IDLE
owner  out  2  index of the current or last granted client
err_timeout  out  1  one-cycle pulse on timeout
err_id  out  2  client index that timed out; held until the next timeout

Behaviour:
- Reset (sync, rst=1 at posedge) from any state:
  - state=IDLE; mem_req=0; mem_start_addr=0; mem_size_bytes=0.
  - cl_valid=0; busy=0; owner=0; err_timeout=0; err_id=0.
  - rr_ptr=0; timeout counter=0.
  - An in-flight read is abandoned; a late mem_valid arriving in IDLE is ignored.
- States:
  - IDLE -> GRANT: when any cl_req=1.
  - GRANT -> REQ: unconditional, 1 cycle.
  - REQ -> DONE: on mem_valid, or on timeout.
  - DONE -> IDLE: unconditional, 1 cycle.
- IDLE arbitration (round robin):
  - Search starts at rr_ptr and wraps: rr_ptr, rr_ptr+1, ... mod NUM_REQ. First active request wins.
  - Winner is registered into owner; its cl_addr/cl_size are latched into mem_start_addr/mem_size_bytes.
- GRANT: mem_req goes to 1 on the next edge (registered). Latency from cl_req to mem_req is 2 cycles.
- REQ:
  - mem_req is held at 1 and the address/size stay stable.
  - On a cycle with mem_valid=1:
    - cl_valid[owner]=1 combinationally, the same cycle.
    - cl_data=mem_data and cl_last_valid=mem_last_valid (pass-through).
    - mem_req=0 from the next cycle; rr_ptr=(owner+1) mod NUM_REQ.
- Timeout:
  - The counter counts cycles in REQ. When it reaches TIMEOUT_CYC-1 with mem_valid=0: err_timeout pulses 1 cycle, err_id=owner, cl_valid stays 0.
  - mem_req drops next cycle; rr_ptr advances; go to DONE.
  - mem_valid in the same cycle as the terminal count: mem_valid wins, no error.
- DONE: cl_req is ignored for this one cycle, so the owner has one cycle to drop cl_req after its cl_valid. An owner still requesting in the following IDLE is re-arbitrated normally.
- Outside REQ: cl_valid=0 and cl_data=0. mem_valid in IDLE, GRANT or DONE is ignored.
- cl_addr/cl_size changes after grant have no effect until the next grant.
- Throughput: 4 cycles per transaction with zero memory latency (IDLE, GRANT, REQ, DONE).

Test Plan:
1. Single pic request: cl_req=001, addr=0x80, size=4; memory returns mem_valid 3 cycles after mem_req, last_valid=3 -> mem_req rises 2 cycles after cl_req; mem_start_addr=0x80, mem_size_bytes=4; cl_valid=001 exactly 1 cycle with the data passed through; busy drops 2 cycles later.
2. All three requests asserted simultaneously from reset, each client dropping its req after its valid -> grant order pic, wgt, bias; owner=0,1,2; exactly 3 mem_req pulses.
3. Fairness: pic and bias held high continuously, re-asserted after DONE -> grants alternate 0,2,0,2; wgt never granted; no client starves.
4. Timeout: TIMEOUT_CYC=16, wgt request, memory never responds -> err_timeout pulses on the 16th REQ cycle; err_id=1; cl_valid stays 000; mem_req drops; FSM returns to IDLE; next pending request is served normally.
5. Boundary: TIMEOUT_CYC=16, mem_valid arrives exactly on the 16th REQ cycle -> cl_valid asserted, err_timeout=0.
6. Reset mid-operation: rst=1 in REQ with mem_req=1 -> next cycle mem_req=0, busy=0, owner=0; a stale mem_valid after reset produces no cl_valid.
